// File: rtl/matvec_pkg.sv
// Width and latency helpers shared by the matrix-vector engine and its output streamer.
package matvec_pkg;

  function automatic int lat_f(input int c);
    return $clog2(c) + 1;
  endfunction

  function automatic int wy_f(input int wx, input int wk, input int c);
    return wx + wk + $clog2(c);
  endfunction

endpackage

// File: rtl/vec_fifo2.sv
// Two-entry FIFO holding whole result vectors; writes are ignored when full, reads when empty.
module vec_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign wr_en   = wr_i && !full_o;
  assign rd_en   = rd_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 2'd1;
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (wr_en) wptr_q <= ~wptr_q;
      if (rd_en) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/matvec_out_stream.sv
// Drives the engine clock enable, tracks in-flight vectors with tags, buffers results
// and streams them out one row element at a time.
module matvec_out_stream
  import matvec_pkg::*;
#(
  parameter  int R   = 8,
  parameter  int C   = 8,
  parameter  int W_X = 8,
  parameter  int W_K = 8,
  localparam int LAT = lat_f(C),
  localparam int W_Y = wy_f(W_X, W_K, C)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          mv_cen,
  input  logic signed [R-1:0][W_Y-1:0]  mv_y,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [W_Y-1:0]         m_data,
  output logic                          m_last
);

  localparam int RW = (R > 1) ? $clog2(R) : 1;

  logic [LAT-1:0]         tag_q, tag_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   fifo_full, fifo_empty;
  logic                   wr, pop;
  logic [R-1:0][W_Y-1:0]  head;

  // The engine freezes only when a finished result has nowhere to go.
  assign mv_cen  = !(tag_q[LAT-1] && fifo_full);
  assign s_ready = mv_cen;
  assign wr      = tag_q[LAT-1] && !fifo_full;

  assign m_valid = !fifo_empty;
  assign m_last  = (row_q == RW'(R - 1));
  assign m_data  = head[row_q];
  assign pop     = m_valid && m_ready && m_last;

  always_comb begin
    tag_d = tag_q;
    if (mv_cen) begin
      tag_d[0] = s_valid && s_ready;
      for (int i = 1; i < LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_comb begin
    row_d = row_q;
    if (m_valid && m_ready) begin
      row_d = m_last ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_q <= '0;
      row_q <= '0;
    end else begin
      tag_q <= tag_d;
      row_q <= row_d;
    end
  end

  vec_fifo2 #(
    .DW(R * W_Y)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_i    (wr),
    .wdata_i (mv_y),
    .rd_i    (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_matvec_out_stream.sv
// Bench for matvec_out_stream with a behavioural pipelined engine and an element scoreboard.
module tb_matvec_out_stream;
  import matvec_pkg::*;

  localparam int R   = 4;
  localparam int C   = 8;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int LAT = lat_f(C);
  localparam int W_Y = wy_f(W_X, W_K, C);

  typedef logic [R-1:0][W_Y-1:0] yvec_t;
  typedef struct {
    logic signed [W_Y-1:0] data;
    logic                  last;
  } elem_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   s_valid;
  logic                   s_ready;
  logic                   mv_cen;
  yvec_t                  mv_y;
  logic                   m_valid;
  logic                   m_ready;
  logic signed [W_Y-1:0]  m_data;
  logic                   m_last;

  logic signed [W_X-1:0]  xv [C];
  logic signed [W_K-1:0]  km [R][C];
  yvec_t                  pipe [LAT];

  elem_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    outCnt = 0;
  int    cyc = 0;
  int    firstOutCyc = -1;
  int    lastOutCyc = -1;

  matvec_out_stream #(
    .R(R), .C(C), .W_X(W_X), .W_K(W_K)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .mv_cen  (mv_cen),
    .mv_y    (mv_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic yvec_t modelY();
    yvec_t y;
    for (int r = 0; r < R; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < C; c++) acc += int'(xv[c]) * int'(km[r][c]);
      y[r] = W_Y'(acc);
    end
    return y;
  endfunction

  // Reference engine: LAT enabled stages, frozen whenever mv_cen is low.
  always @(posedge clk) begin
    if (mv_cen === 1'b1) begin
      pipe[0] <= modelY();
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mv_y = pipe[LAT-1];

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input int xval, input int kval);
    s_valid = sv;
    for (int c = 0; c < C; c++) xv[c] = W_X'(xval);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) km[r][c] = W_K'(kval);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < budget);
    checkOutput(tag, m_valid, 1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < budget);
    checkOutput(tag, exp_q.size(), 0);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  logic                  stallPrev = 1'b0;
  logic signed [W_Y-1:0] prevData;
  logic                  prevLast;
  yvec_t                 pushY;
  elem_t                 e;

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      exp_q.delete();
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, prevData);
        checkOutput("stall_last", m_last, prevLast);
      end
      if (m_valid && m_ready) begin
        outCnt++;
        if (firstOutCyc < 0) firstOutCyc = cyc;
        lastOutCyc = cyc;
        checkOutput("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("sb_data", m_data, e.data);
          checkOutput("sb_last", m_last, e.last);
        end
      end
      if (s_valid && s_ready) begin
        pushY = modelY();
        for (int r = 0; r < R; r++) exp_q.push_back('{data: pushY[r], last: (r == R - 1)});
      end
      stallPrev = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  initial begin
    int accepted, sawStall, guard, o0;
    rstn = 1'b0;
    m_ready = 1'b0;
    applyStimulus(1'b0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_mv_cen", mv_cen, 1);

    // Single vector, latency and last marker.
    nextCycle();
    rstn = 1'b1;
    m_ready = 1'b1;
    applyStimulus(1'b1, 1, 2);
    nextCycle();
    s_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checkOutput($sformatf("lat_valid_c%0d", c), m_valid, (c >= 5 && c <= 8) ? 1 : 0);
      checkOutput($sformatf("lat_last_c%0d", c), m_last, (c == 8) ? 1 : 0);
      if (c >= 5 && c <= 8) checkOutput($sformatf("lat_data_c%0d", c), m_data, 16);
    end
    waitDrain("single_drain", 20);

    // Back-to-back stream of eight distinct vectors.
    nextCycle();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) km[r][c] = W_K'(r * 3 - c);
    accepted = 0;
    sawStall = 0;
    guard = 0;
    o0 = outCnt;
    firstOutCyc = -1;
    while (accepted < 8 && guard < 200) begin
      s_valid = 1'b1;
      for (int c = 0; c < C; c++) xv[c] = W_X'(accepted * 7 + c - 20);
      @(negedge clk);
      if (s_ready) accepted++;
      else sawStall = 1;
      nextCycle();
      guard++;
    end
    s_valid = 1'b0;
    checkOutput("b2b_accepted", accepted, 8);
    checkOutput("b2b_stall_seen", sawStall, 1);
    waitDrain("b2b_drain", 200);
    checkOutput("b2b_count", outCnt - o0, 32);
    checkOutput("b2b_gapless", lastOutCyc - firstOutCyc + 1, 32);

    // Backpressure: three vectors with the sink stalled.
    nextCycle();
    m_ready = 1'b0;
    o0 = outCnt;
    for (int v = 0; v < 3; v++) begin
      s_valid = 1'b1;
      for (int c = 0; c < C; c++) xv[c] = W_X'(v * 11 - c);
      @(negedge clk);
      checkOutput($sformatf("bp_accept_%0d", v), s_ready, 1);
      nextCycle();
    end
    s_valid = 1'b0;
    repeat (8) nextCycle();
    @(negedge clk);
    checkOutput("bp_mv_cen", mv_cen, 0);
    checkOutput("bp_s_ready", s_ready, 0);
    checkOutput("bp_m_valid", m_valid, 1);
    checkOutput("bp_sb_held", exp_q.size(), 12);
    nextCycle();
    m_ready = 1'b1;
    waitDrain("bp_drain", 100);
    checkOutput("bp_count", outCnt - o0, 12);

    // Signed extremes.
    nextCycle();
    applyStimulus(1'b1, -128, -128);
    nextCycle();
    s_valid = 1'b0;
    waitValid("sx1_valid", 20);
    checkOutput("sx_neg_neg", m_data, 131072);
    waitDrain("sx1_drain", 20);
    nextCycle();
    applyStimulus(1'b1, 127, -128);
    nextCycle();
    s_valid = 1'b0;
    waitValid("sx2_valid", 20);
    checkOutput("sx_pos_neg", m_data, -130048);
    waitDrain("sx2_drain", 20);

    // Reset in the middle of a buffered vector.
    nextCycle();
    m_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      applyStimulus(1'b1, v + 2, 3);
      nextCycle();
    end
    s_valid = 1'b0;
    repeat (8) nextCycle();
    m_ready = 1'b1;
    nextCycle();
    nextCycle();
    m_ready = 1'b0;
    rstn = 1'b0;
    nextCycle();
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_m_valid", m_valid, 0);
    checkOutput("mid_rst_s_ready", s_ready, 1);
    checkOutput("mid_rst_mv_cen", mv_cen, 1);
    checkOutput("mid_rst_m_last", m_last, 0);
    nextCycle();
    o0 = outCnt;
    m_ready = 1'b1;
    applyStimulus(1'b1, 5, -3);
    nextCycle();
    s_valid = 1'b0;
    waitValid("mid_rst_valid", 20);
    checkOutput("mid_rst_row0_last", m_last, 0);
    checkOutput("mid_rst_row0_data", m_data, -120);
    waitDrain("mid_rst_drain", 20);
    checkOutput("mid_rst_count", outCnt - o0, 4);

    // Random traffic on both sides.
    nextCycle();
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < C; c++) xv[c] = W_X'($urandom);
      if ((i % 16) == 0)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) km[r][c] = W_K'($urandom);
      nextCycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    waitDrain("rand_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
